// File: rtl/icache_miss_responder.sv
// Fixed-latency main-memory end of the icache miss protocol, with a one-entry pending buffer.
// Define ICACHE_MISS_RSP_STATS_EN to add request/error/drop counters.
module icache_miss_responder #(
    parameter int LATENCY   = 4,
    parameter int MEM_LINES = 256
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid_miss,
    input  logic [148:0] req_info_miss,
    output logic         rsp_valid_miss,
    output logic [127:0] rsp_data_miss,
    output logic         rsp_bus_error,
    input  logic         load_valid,
    input  logic [15:0]  load_line,
    input  logic [127:0] load_data,
    output logic         busy,
    output logic         drop_sticky
`ifdef ICACHE_MISS_RSP_STATS_EN
    ,
    output logic [31:0]  stat_req_cnt,
    output logic [31:0]  stat_err_cnt,
    output logic [15:0]  stat_drop_cnt
`endif
);

    localparam int         AW        = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam logic [3:0] CNT_START = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         start_state;
    logic [3:0]     cnt;

    logic [15:0]    svc_line;
    logic           svc_store;
    logic [127:0]   svc_data;

    logic           buf_valid;
    logic [15:0]    buf_line;
    logic           buf_store;
    logic [127:0]   buf_data;

    logic [127:0]   mem [MEM_LINES];

    logic [15:0]    req_line;
    logic           req_store;
    logic [127:0]   req_data;
    logic           req_drop;
    logic           resp_active;
    logic           svc_mapped;
    logic           store_we;
    logic           load_we;

    function automatic logic is_mapped(input logic [15:0] line);
        return {1'b0, line} < 17'(MEM_LINES);
    endfunction

    // Address bits [3:0] select a byte within the line and are not needed here.
    assign req_line    = req_info_miss[148:133];
    assign req_store   = req_info_miss[128];
    assign req_data    = req_info_miss[127:0];
    assign start_state = (LATENCY == 1) ? RESP : WAIT;

    assign req_drop    = req_valid_miss && (state != IDLE) && buf_valid;
    assign resp_active = (state == RESP);
    assign svc_mapped  = is_mapped(svc_line);
    assign store_we    = resp_active && svc_store && svc_mapped && !reset;
    assign load_we     = load_valid && is_mapped(load_line);

    // Read happens in the RESP cycle itself so earlier preloads and stores are visible.
    assign rsp_valid_miss = resp_active;
    assign rsp_bus_error  = resp_active && !svc_mapped;
    assign rsp_data_miss  = (resp_active && !svc_store && svc_mapped) ? mem[svc_line[AW-1:0]] : '0;
    assign busy           = (state != IDLE) || buf_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            svc_line    <= '0;
            svc_store   <= 1'b0;
            svc_data    <= '0;
            buf_valid   <= 1'b0;
            buf_line    <= '0;
            buf_store   <= 1'b0;
            buf_data    <= '0;
            drop_sticky <= 1'b0;
        end else begin
            if (req_drop) begin
                drop_sticky <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req_valid_miss) begin
                        svc_line  <= req_line;
                        svc_store <= req_store;
                        svc_data  <= req_data;
                        cnt       <= CNT_START;
                        state     <= start_state;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                    if (req_valid_miss && !buf_valid) begin
                        buf_valid <= 1'b1;
                        buf_line  <= req_line;
                        buf_store <= req_store;
                        buf_data  <= req_data;
                    end
                end
                RESP: begin
                    // Back-to-back service: the buffer drains first, else a fresh strobe is taken directly.
                    if (buf_valid) begin
                        svc_line  <= buf_line;
                        svc_store <= buf_store;
                        svc_data  <= buf_data;
                        buf_valid <= 1'b0;
                        cnt       <= CNT_START;
                        state     <= start_state;
                    end else if (req_valid_miss) begin
                        svc_line  <= req_line;
                        svc_store <= req_store;
                        svc_data  <= req_data;
                        cnt       <= CNT_START;
                        state     <= start_state;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Backing store has no reset; a same-edge preload overrides a store to the same line.
    always_ff @(posedge clock) begin
        if (store_we) begin
            mem[svc_line[AW-1:0]] <= svc_data;
        end
        if (load_we) begin
            mem[load_line[AW-1:0]] <= load_data;
        end
    end

`ifdef ICACHE_MISS_RSP_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_req_cnt  <= '0;
            stat_err_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (req_valid_miss && !req_drop) begin
                stat_req_cnt <= stat_req_cnt + 32'd1;
            end
            if (resp_active && !svc_mapped) begin
                stat_err_cnt <= stat_err_cnt + 32'd1;
            end
            if (req_drop) begin
                stat_drop_cnt <= stat_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_miss_responder.sv
// Bench for icache_miss_responder: two instances (LATENCY 4 and 1) share stimulus and are
// compared every cycle against a job-schedule reference model.
module tb_icache_miss_responder;
    localparam int ML = 256;
    localparam logic [127:0] LINE10 = 128'hFFFF_EEEE_DDDD_CCCC_DDDD_CCCC_BBBB_AAAA;
    localparam logic [127:0] STV    = 128'h1234_0000_1111_2222_3333_4444_5555_5678;
    localparam logic [127:0] NEWV   = 128'hA5A5_0001_0203_0405_0607_0809_0A0B_0C0D;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid_miss;
    logic [148:0] req_info_miss;
    logic         load_valid;
    logic [15:0]  load_line;
    logic [127:0] load_data;

    logic         rv0, rv1, re0, re1, bz0, bz1, ds0, ds1;
    logic [127:0] rd0, rd1;

    always #5 clock = ~clock;

    icache_miss_responder #(.LATENCY(4), .MEM_LINES(ML)) u0 (
        .clock(clock), .reset(reset),
        .req_valid_miss(req_valid_miss), .req_info_miss(req_info_miss),
        .rsp_valid_miss(rv0), .rsp_data_miss(rd0), .rsp_bus_error(re0),
        .load_valid(load_valid), .load_line(load_line), .load_data(load_data),
        .busy(bz0), .drop_sticky(ds0)
    );

    icache_miss_responder #(.LATENCY(1), .MEM_LINES(ML)) u1 (
        .clock(clock), .reset(reset),
        .req_valid_miss(req_valid_miss), .req_info_miss(req_info_miss),
        .rsp_valid_miss(rv1), .rsp_data_miss(rd1), .rsp_bus_error(re1),
        .load_valid(load_valid), .load_line(load_line), .load_data(load_data),
        .busy(bz1), .drop_sticky(ds1)
    );

    // A job occupies its responder from start edge s; its response is visible in the cycle after edge r.
    typedef struct {
        int           inst;
        int           s;
        int           r;
        bit           st;
        int           line;
        logic [127:0] d;
    } job_t;

    job_t         jobs[$];
    logic [127:0] mm [2][ML];
    bit           sticky [2];
    int           lat [2];
    int           n;
    int           tests;
    int           fails;
    int           rsp_seen_n;
    logic [127:0] rsp_seen_d;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rq, input logic [148:0] info, input logic lv,
                              input logic [15:0] ll, input logic [127:0] ld, input logic rst);
        bit   pend;
        int   last_r;
        job_t j;
        n++;
        if (!rst) begin
            foreach (jobs[k]) begin
                if (jobs[k].r == n - 1 && jobs[k].st && jobs[k].line < ML) begin
                    mm[jobs[k].inst][jobs[k].line] = jobs[k].d;
                end
            end
        end
        if (lv && int'(ll) < ML) begin
            for (int i = 0; i < 2; i++) mm[i][ll] = ld;
        end
        if (rst) begin
            jobs.delete();
            sticky[0] = 1'b0;
            sticky[1] = 1'b0;
        end else begin
            for (int k = jobs.size() - 1; k >= 0; k--) begin
                if (jobs[k].r < n) jobs.delete(k);
            end
            if (rq) begin
                for (int i = 0; i < 2; i++) begin
                    pend   = 1'b0;
                    last_r = -1000;
                    foreach (jobs[k]) begin
                        if (jobs[k].inst == i) begin
                            if (jobs[k].s >= n) pend = 1'b1;
                            if (jobs[k].r > last_r) last_r = jobs[k].r;
                        end
                    end
                    if (pend) begin
                        sticky[i] = 1'b1;
                    end else begin
                        j.inst = i;
                        j.s    = (n > last_r + 1) ? n : last_r + 1;
                        j.r    = j.s + lat[i] - 1;
                        j.st   = info[128];
                        j.line = int'(info[148:133]);
                        j.d    = info[127:0];
                        jobs.push_back(j);
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic         ev, ee, eb;
        logic [127:0] ed;
        for (int i = 0; i < 2; i++) begin
            ev = 1'b0; ee = 1'b0; eb = 1'b0; ed = '0;
            foreach (jobs[k]) begin
                if (jobs[k].inst == i) begin
                    if (jobs[k].r >= n) eb = 1'b1;
                    if (jobs[k].r == n) begin
                        ev = 1'b1;
                        if (jobs[k].line >= ML) ee = 1'b1;
                        else if (!jobs[k].st) ed = mm[i][jobs[k].line];
                    end
                end
            end
            check($sformatf("rsp_valid[%0d]@%0d", i, n), 128'(i == 0 ? rv0 : rv1), 128'(ev));
            check($sformatf("rsp_data[%0d]@%0d", i, n), i == 0 ? rd0 : rd1, ed);
            check($sformatf("bus_error[%0d]@%0d", i, n), 128'(i == 0 ? re0 : re1), 128'(ee));
            check($sformatf("busy[%0d]@%0d", i, n), 128'(i == 0 ? bz0 : bz1), 128'(eb));
            check($sformatf("drop_sticky[%0d]@%0d", i, n), 128'(i == 0 ? ds0 : ds1), 128'(sticky[i]));
        end
    endtask

    task automatic step(input logic rq, input logic [148:0] info, input logic lv,
                        input logic [15:0] ll, input logic [127:0] ld, input logic rst);
        reset          = rst;
        req_valid_miss = rq;
        req_info_miss  = info;
        load_valid     = lv;
        load_line      = ll;
        load_data      = ld;
        @(posedge clock);
        model_edge(rq, info, lv, ll, ld, rst);
        @(negedge clock);
        check_outputs();
        if (rv0 === 1'b1 && rsp_seen_n < 0) begin
            rsp_seen_n = n;
            rsp_seen_d = rd0;
        end
        reset          = 1'b0;
        req_valid_miss = 1'b0;
        load_valid     = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    function automatic logic [148:0] req(input logic [19:0] addr, input logic st, input logic [127:0] d);
        return {addr, st, d};
    endfunction

    initial begin
        int req_n;
        logic [15:0] rline;
        logic [148:0] rinfo;
        lat[0] = 4; lat[1] = 1;
        n = 0; tests = 0; fails = 0;
        rsp_seen_n = -1; rsp_seen_d = '0;
        sticky[0] = 1'b0; sticky[1] = 1'b0;
        for (int i = 0; i < 2; i++) for (int l = 0; l < ML; l++) mm[i][l] = '0;
        reset = 1'b1; req_valid_miss = 1'b0; req_info_miss = '0;
        load_valid = 1'b0; load_line = '0; load_data = '0;
        @(negedge clock);

        // Reset, then preload every line so no read can return uninitialised data.
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        for (int l = 0; l < ML; l++) begin
            step(1'b0, '0, 1'b1, 16'(l),
                 (l == 16) ? LINE10 : {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end

        // Mapped load: latency and data.
        rsp_seen_n = -1;
        req_n = n + 1;
        step(1'b1, req(20'h00100, 1'b0, '0), 1'b0, '0, '0, 1'b0);
        idle(6);
        check("load_latency", 128'(rsp_seen_n - req_n), 128'(3));
        check("load_data_dir", rsp_seen_d, LINE10);

        // Unmapped load.
        step(1'b1, req(20'h01000, 1'b0, '0), 1'b0, '0, '0, 1'b0);
        idle(6);

        // Store then load the same line.
        step(1'b1, req(20'h00200, 1'b1, STV), 1'b0, '0, '0, 1'b0);
        idle(6);
        rsp_seen_n = -1;
        step(1'b1, req(20'h00200, 1'b0, '0), 1'b0, '0, '0, 1'b0);
        idle(6);
        check("store_readback", rsp_seen_d, STV);

        // Three back-to-back strobes: third dropped on the LATENCY=4 instance only.
        step(1'b1, req(20'h00010, 1'b0, '0), 1'b0, '0, '0, 1'b0);
        step(1'b1, req(20'h00020, 1'b0, '0), 1'b0, '0, '0, 1'b0);
        step(1'b1, req(20'h00030, 1'b0, '0), 1'b0, '0, '0, 1'b0);
        idle(12);
        check("drop_sticky_l4", 128'(ds0), 128'(1));
        check("drop_sticky_l1", 128'(ds1), 128'(0));

        // Reset while waiting with the buffer full; preloaded data survives.
        step(1'b1, req(20'h00040, 1'b1, NEWV), 1'b0, '0, '0, 1'b0);
        step(1'b1, req(20'h00050, 1'b0, '0), 1'b0, '0, '0, 1'b0);
        idle(1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        check("busy_after_reset", 128'(bz0), 128'(0));
        idle(2);
        rsp_seen_n = -1;
        step(1'b1, req(20'h00100, 1'b0, '0), 1'b0, '0, '0, 1'b0);
        idle(6);
        check("preload_survives_reset", rsp_seen_d, LINE10);

        // LATENCY=1: preload on the request edge is seen by the response.
        step(1'b1, req(20'h00500, 1'b0, '0), 1'b1, 16'h0050, NEWV, 1'b0);
        check("l1_same_edge_load", rd1, NEWV);
        idle(6);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) == 0) rline = 16'($urandom_range(ML, 65535));
            else rline = 16'($urandom_range(0, ML - 1));
            rinfo = {rline, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0),
                     $urandom, $urandom, $urandom, $urandom};
            step(1'($urandom_range(0, 2) == 0), rinfo,
                 1'($urandom_range(0, 4) == 0), 16'($urandom_range(0, 300)),
                 {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 99) == 0));
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
